// File: rtl/switch_output_queue.sv
// switch_output_queue: per-port store-and-forward packet buffer.
// Complete packets are committed; a packet that overflows the buffer is dropped whole.
// Stored packets drain one at a time onto the 8-bit output port under ready/grant.
// Optional feature: define SWITCH_OQ_STATS_EN to add the sent_count/drop_count statistics outputs.
module switch_output_queue #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic          grant,
  output logic [7:0]    port,
  output logic          ready,
  output logic          read,
  output logic [AW:0]   pkt_count,
  output logic          drop_pulse
`ifdef SWITCH_OQ_STATS_EN
  ,
  output logic [15:0]   sent_count,
  output logic [15:0]   drop_count
`endif
);

  typedef enum logic {WR_ACCEPT, WR_DISCARD} wr_state_e;
  typedef enum logic {RD_IDLE, RD_SEND} rd_state_e;

  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_VAL = (AW+1)'(DEPTH);

  // Each entry holds {last flag, data byte}.
  logic [8:0] mem [DEPTH];

  wr_state_e   wr_state_q, wr_state_d;
  rd_state_e   rd_state_q, rd_state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] pkt_start_q, pkt_start_d;
  logic [AW:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0]  port_q, port_d;
  logic        read_q, read_d;
  logic        drop_q, drop_d;

  logic [AW:0] occupancy;
  logic        full;
  logic        mem_we;
  logic        commit;
  logic        done;
  logic [8:0]  rd_entry;

  // Pointers carry one extra wrap bit so the difference is the true occupancy.
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign full      = (occupancy == DEPTH_VAL);
  assign rd_entry  = mem[rd_ptr_q[AW-1:0]];
  assign ready     = (rd_state_q == RD_IDLE) && (pkt_cnt_q != '0);

  // Write FSM: store bytes, commit on last, rewind to packet start on overflow.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_state_d  = wr_state_q;
    wr_ptr_d    = wr_ptr_q;
    pkt_start_d = pkt_start_q;
    mem_we      = 1'b0;
    commit      = 1'b0;
    drop_d      = 1'b0;
    case (wr_state_q)
      WR_ACCEPT: begin
        if (in_valid) begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (in_last) begin
              pkt_start_d = wr_ptr_q + PTR_ONE;
              commit      = 1'b1;
            end
          end else begin
            wr_ptr_d = pkt_start_q;
            drop_d   = 1'b1;
            if (!in_last) wr_state_d = WR_DISCARD;
          end
        end
      end
      WR_DISCARD: begin
        if (in_valid && in_last) wr_state_d = WR_ACCEPT;
      end
      default: wr_state_d = WR_ACCEPT;
    endcase
  end

  // Read FSM: wait for ready && grant, then stream one packet back-to-back.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    port_d     = port_q;
    read_d     = 1'b0;
    done       = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        if (ready && grant) rd_state_d = RD_SEND;
      end
      RD_SEND: begin
        port_d   = rd_entry[7:0];
        read_d   = 1'b1;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (rd_entry[8]) begin
          done       = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Packet count: a simultaneous commit and end-of-drain cancel out.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q + (AW+1)'(commit) - (AW+1)'(done);
  end

  // State and pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      wr_state_q  <= WR_ACCEPT;
      rd_state_q  <= RD_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_start_q <= '0;
      pkt_cnt_q   <= '0;
      port_q      <= '0;
      read_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      rd_state_q  <= rd_state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_start_q <= pkt_start_d;
      pkt_cnt_q   <= pkt_cnt_d;
      port_q      <= port_d;
      read_q      <= read_d;
      drop_q      <= drop_d;
    end
  end

  // Packet storage.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is not reset; cleared pointers make stale entries unreachable.
    if (mem_we) mem[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
  end

  assign port       = port_q;
  assign read       = read_q;
  assign pkt_count  = pkt_cnt_q;
  assign drop_pulse = drop_q;

`ifdef SWITCH_OQ_STATS_EN
  logic [15:0] sent_cnt_q, sent_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating statistics counters.
  always_comb begin
    sent_cnt_d = sent_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (done && (sent_cnt_q != 16'hFFFF)) sent_cnt_d = sent_cnt_q + 16'd1;
    if (drop_q && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      sent_cnt_q <= sent_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign sent_count = sent_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_switch_output_queue.sv
// Bench for switch_output_queue: directed scenarios plus randomized traffic,
// compared every cycle against a packet-level reference model.
module tb_switch_output_queue;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          grant = 1'b0;
  logic [7:0]    port;
  logic          ready;
  logic          read;
  logic [AW:0]   pkt_count;
  logic          drop_pulse;
`ifdef SWITCH_OQ_STATS_EN
  logic [15:0]   sent_count;
  logic [15:0]   drop_count;
`endif

  switch_output_queue #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .grant      (grant),
    .port       (port),
    .ready      (ready),
    .read       (read),
    .pkt_count  (pkt_count),
    .drop_pulse (drop_pulse)
`ifdef SWITCH_OQ_STATS_EN
    ,
    .sent_count (sent_count),
    .drop_count (drop_count)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: bytes of committed packets in order, the packet being
  // written, and byte-level occupancy of the buffer.
  logic [8:0] exp_bytes[$];
  logic [8:0] partial[$];
  int         occ = 0;
  bit         discarding = 0;
  bit         rd_busy = 0;
  bit         prev_ready = 0;
  int         commits = 0;
  int         completions = 0;
  int         drops = 0;
  int         sim_events = 0;
  int         reads_total = 0;
  int         bytes_in_pkt = 0;
  logic [7:0] port_exp = '0;
  bit         grant_rand = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_bytes.delete();
    partial.delete();
    occ = 0; discarding = 0; rd_busy = 0; prev_ready = 0;
    commits = 0; completions = 0; drops = 0; bytes_in_pkt = 0;
    port_exp = '0;
  endtask

  // Reset is raised between clock edges so its effect must be asynchronous.
  task automatic do_reset();
    in_valid = 1'b0; in_last = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_read", read, 0);
    check("rst_ready", ready, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_drop_pulse", drop_pulse, 0);
    check("rst_port", port, 0);
    model_clear();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One clock: advance to the falling edge, update the model with the inputs
  // that were present at the rising edge, and compare all outputs.
  task automatic cycle();
    bit drop_now, commit_now, done_now, exp_read, exp_ready;
    logic [8:0] e;
    @(posedge clock);
    @(negedge clock);
    drop_now = 0; commit_now = 0; done_now = 0;
    if (in_valid) begin
      if (discarding) begin
        if (in_last) discarding = 0;
      end else if (occ == DEPTH) begin
        drop_now = 1;
        occ -= partial.size();
        partial.delete();
        if (!in_last) discarding = 1;
      end else begin
        partial.push_back({in_last, in_data});
        occ++;
        if (in_last) begin
          commit_now = 1;
          foreach (partial[i]) exp_bytes.push_back(partial[i]);
          partial.delete();
        end
      end
    end
    exp_read = rd_busy;
    check("read", read, exp_read);
    if (exp_read) begin
      if (exp_bytes.size() == 0) begin
        check("model_underrun", 0, 1);
        rd_busy = 0;
      end else begin
        e = exp_bytes.pop_front();
        port_exp = e[7:0];
        occ--;
        reads_total++;
        bytes_in_pkt++;
        if (e[8]) begin
          done_now = 1;
          rd_busy = 0;
        end
      end
    end else if (prev_ready && grant) begin
      rd_busy = 1;
      bytes_in_pkt = 0;
    end
    if (commit_now) commits++;
    if (done_now) completions++;
    if (drop_now) drops++;
    if (commit_now && done_now) sim_events++;
    check("port", port, port_exp);
    check("pkt_count", pkt_count, commits - completions);
    check("drop_pulse", drop_pulse, drop_now);
    exp_ready = !rd_busy && (commits != completions);
    check("ready", ready, exp_ready);
    prev_ready = exp_ready;
    if (grant_rand) grant = 1'($urandom_range(0, 1));
  endtask

  task automatic put_byte(input logic [7:0] d, input bit last);
    in_valid = 1'b1; in_data = d; in_last = last;
    cycle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [7:0] base, input bit rnd, input bit gaps);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      d = rnd ? 8'($urandom) : base + 8'(i);
      if (gaps && ($urandom_range(0, 3) == 0)) cycle();
      put_byte(d, i == len - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (((commits != completions) || rd_busy) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 32'((commits == completions) && !rd_busy), 1);
  endtask

  task automatic wait_completions(input string tag, input int target, input int budget);
    int n = 0;
    while ((completions < target) && n < budget) begin
      cycle();
      n++;
    end
    check(tag, completions, target);
  endtask

  initial begin
    int r0, d0, c0, n;

    #1;
    do_reset();

    // Single packet, grant held high.
    grant = 1'b1;
    r0 = reads_total;
    send_pkt(5, 8'h11, 0, 0);
    check("single_ready_after_last", ready, 1);
    check("single_count", pkt_count, 1);
    wait_drain("single_drain", 50);
    idle(1);
    check("single_reads", reads_total - r0, 5);
    check("single_ready_after", ready, 0);
    check("single_count_after", pkt_count, 0);

    // Hold-off: three packets stored, then released one per grant pulse.
    grant = 1'b0;
    send_pkt(4, 8'h20, 0, 0);
    send_pkt(2, 8'h30, 0, 0);
    send_pkt(7, 8'h40, 0, 0);
    idle(2);
    check("holdoff_count", pkt_count, 3);
    check("holdoff_ready", ready, 1);
    c0 = completions;
    for (int p = 1; p <= 3; p++) begin
      grant = 1'b1;
      cycle();
      grant = 1'b0;
      wait_completions("holdoff_pkt_done", c0 + p, 30);
      idle(1);
    end
    check("holdoff_empty", pkt_count, 0);

    // Overflow: 60 bytes stored, 10-byte packet dropped, 4-byte packet fits.
    d0 = drops;
    send_pkt(60, 8'h80, 0, 0);
    send_pkt(10, 8'hC0, 0, 0);
    idle(1);
    check("ovf_drops", drops - d0, 1);
    check("ovf_count", pkt_count, 1);
    send_pkt(4, 8'hE0, 0, 0);
    idle(1);
    check("ovf_count_after", pkt_count, 2);
    grant = 1'b1;
    wait_drain("ovf_drain", 300);

    // Oversize packet into an empty queue.
    grant = 1'b0;
    d0 = drops;
    send_pkt(70, 8'h00, 1, 0);
    idle(2);
    check("oversize_drops", drops - d0, 1);
    check("oversize_count", pkt_count, 0);
    check("oversize_ready", ready, 0);
    grant = 1'b1;
    r0 = reads_total;
    send_pkt(3, 8'h5A, 0, 0);
    wait_drain("oversize_next_drain", 50);
    check("oversize_next_reads", reads_total - r0, 3);

    // Commit of a 6-byte packet lines up with the end of a 5-byte drain.
    grant = 1'b0;
    send_pkt(5, 8'hA0, 0, 0);
    idle(1);
    grant = 1'b1;
    send_pkt(6, 8'hB0, 0, 0);
    wait_drain("align_drain", 60);
    check("align_seen", 32'(sim_events > 0), 1);

    // Wrap: stream 40-byte packets while draining.
    grant = 1'b1;
    for (int p = 0; p < 8; p++) send_pkt(40, 8'h00, 1, 1);
    wait_drain("wrap_drain", 2000);

    // Random mix of lengths with random grant.
    grant_rand = 1;
    for (int p = 0; p < 30; p++) send_pkt($urandom_range(1, 20), 8'h00, 1, 1);
    grant_rand = 0;
    grant = 1'b1;
    wait_drain("random_drain", 3000);

    // Reset on the third byte of an 8-byte drain.
    grant = 1'b0;
    send_pkt(8, 8'h60, 0, 0);
    grant = 1'b1;
    n = 0;
    while (!(rd_busy && bytes_in_pkt == 3) && n < 40) begin
      cycle();
      n++;
    end
    check("midsend_reached", 32'(rd_busy && bytes_in_pkt == 3), 1);
    do_reset();
    idle(1);
    check("post_reset_count", pkt_count, 0);
    r0 = reads_total;
    send_pkt(2, 8'h77, 0, 0);
    wait_drain("post_reset_drain", 30);
    check("post_reset_reads", reads_total - r0, 2);

`ifdef SWITCH_OQ_STATS_EN
    idle(1);
    check("stats_sent", sent_count, completions);
    check("stats_drop", drop_count, drops);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_output_queue.md
Name: switch_output_queue

Overview:
Per-port store-and-forward packet buffer in the switch datapath, directly upstream of each output port pins (port, ready, read).
- Accepts routed bytes from the crossbar.
- Commits only complete packets; drops a whole packet on overflow.
- Drains one packet at a time onto the 8-bit output port under a ready/grant handshake, with read as the byte-valid strobe.

Parameters:
DEPTH, 64, buffer capacity in bytes; power of two, >= 4
AW, $clog2(DEPTH), buffer address width (derived, not overridden)

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  8  packet byte from crossbar
in_valid  input  1  in_data valid this cycle
in_last  input  1  qualifies final byte of packet (with in_valid)
grant  input  1  downstream accepts a packet; sampled while ready=1
port  output  8  output byte, registered
ready  output  1  at least one complete packet stored
read  output  1  port carries a valid byte this cycle
pkt_count  output  AW+1  complete packets stored
drop_pulse  output  1  one-cycle pulse when a packet is discarded

Behaviour:
- Reset (async, active-high) values: port=0, ready=0, read=0, pkt_count=0, drop_pulse=0. Pointers cleared, both FSMs to idle state. Reset mid-packet discards all content, including partial writes.
- Storage: DEPTH x 9-bit entries (data, last flag).
- Pointers: wr_ptr, rd_ptr, pkt_start are AW+1 bits. Occupancy = wr_ptr - rd_ptr, computed modulo 2^(AW+1), so wrap-around is transparent.
- Full = occupancy == DEPTH, evaluated on registered state. Space freed by a read in cycle N is usable from cycle N+1; there is no same-cycle bypass.
- Write FSM, ACCEPT state:
  - in_valid && !full: write the byte, wr_ptr++.
  - If in_last is also set: pkt_start <= wr_ptr+1 and the packet is committed.
  - in_valid && full: wr_ptr <= pkt_start (rewind), drop_pulse=1 next cycle. If in_last is set, stay in ACCEPT; otherwise go to DISCARD.
- Write FSM, DISCARD state: ignore bytes; on in_valid && in_last, return to ACCEPT.
- Packets longer than DEPTH are therefore always dropped.
- Commit: pkt_count++ the cycle after the last byte is written. A packet is never visible before its last byte is stored (no cut-through).
- Read FSM, IDLE state: ready = (pkt_count != 0). On ready && grant, go to SEND.
- Read FSM, SEND state:
  - Each cycle: port <= mem[rd_ptr], read <= 1, rd_ptr++.
  - On the entry with last=1: pkt_count--, go to IDLE.
  - ready is held 0 in SEND.
  - The first byte appears on port with read=1 one cycle after grant is sampled. Bytes of one packet are back-to-back.
  - There is a minimum one-cycle read=0 gap between packets.
  - grant is ignored outside IDLE.
- Simultaneous commit and end-of-drain in the same cycle: pkt_count is unchanged.
- Simultaneous overflow rewind and read: the rewind affects only wr_ptr; a drain in progress is unaffected.
- When read=0, port holds its last value.

Optional Feature:
Macro SWITCH_OQ_STATS_EN.
- Defined: adds outputs sent_count[15:0] and drop_count[15:0].
  - sent_count increments when the last byte of a packet is driven.
  - drop_count increments with each drop_pulse.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor the counters exist. All other behaviour is identical.

Test Plan:
- Single packet: write 5 bytes 0x11..0x15 (last on 0x15), grant held 1 -> ready rises 1 cycle after the last write; read=1 for exactly 5 cycles with port=0x11..0x15; pkt_count 1->0; ready=0 after.
- Hold-off: write 3 packets (4, 2, 7 bytes) with grant=0 -> pkt_count=3 and ready=1 steady. Then pulse grant per packet -> packets emerge in order with a >=1-cycle read=0 gap between them.
- Overflow drop, DEPTH=64: store a 60-byte packet undrained, then write a 10-byte packet -> drop_pulse once, pkt_count stays 1, wr_ptr back at 60. A following 4-byte packet commits, pkt_count=2.
- Oversize: 70-byte packet into an empty queue -> one drop_pulse, pkt_count=0, ready never asserts. A next 3-byte packet drains correctly.
- Wrap and simultaneity: repeatedly stream 40-byte packets while draining, so pointers wrap several times. Align a commit with end-of-drain -> pkt_count unchanged that cycle; all data intact.
- Reset mid-SEND: assert reset on the 3rd byte of an 8-byte drain -> read, ready and pkt_count go to 0 immediately (asynchronous). After release, the queue is empty and a new 2-byte packet round-trips.
